// File: rtl/dmem_ls_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : dmem_ls_ctrl
// Purpose  : Byte-addressed load/store data memory with req/ready handshake,
//            byte/half/word lanes, load extension, alignment checking and
//            programmable wait states. Optional macro DMEM_RANGE_CHECK_EN
//            rejects offsets beyond the memory span instead of aliasing.
// Revision : 1.0 - initial release
// ============================================================================
module dmem_ls_ctrl #(
    parameter int          DEPTH       = 2048,
    parameter logic [31:0] BASE_ADDR   = 32'h1001_0000,
    parameter int          WAIT_CYCLES = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic        we,
    input  logic [1:0]  size,
    input  logic        sign_ext,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        ready,
    output logic        err,
    output logic        busy
);

    localparam int IW = $clog2(DEPTH);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACCESS = 2'd1;
    localparam logic [1:0] S_RESP   = 2'd2;

    localparam logic [3:0] c_wait = 4'(WAIT_CYCLES);

    logic [1:0]    r_state;
    logic [3:0]    r_cnt;
    logic          r_we;
    logic          r_sign_ext;
    logic          r_err_pend;
    logic [1:0]    r_size;
    logic [IW+1:0] r_off;
    logic [31:0]   r_wdata;
    logic [31:0]   r_rdata;

    logic [31:0]   mem [DEPTH];

    logic [31:0]   w_off;
    logic          w_misaligned;
    logic          w_out_of_range;
    logic [IW-1:0] w_idx;
    logic [1:0]    w_lane;
    logic          w_do_access;
    logic [31:0]   w_word;
    logic [7:0]    w_byte;
    logic [15:0]   w_half;
    logic [31:0]   w_load;
    logic [3:0]    w_be;
    logic [31:0]   w_wlanes;

    assign w_off        = addr - BASE_ADDR;
    assign w_misaligned = (size == 2'b11)
                        | ((size == 2'b01) & w_off[0])
                        | ((size == 2'b10) & (|w_off[1:0]));

`ifdef DMEM_RANGE_CHECK_EN
    assign w_out_of_range = (w_off >> (IW + 2)) != 32'd0;
`else
    // Without the range check the high offset bits simply alias away.
    logic w_unused_off_hi;
    assign w_unused_off_hi = ^w_off[31:IW+2];
    assign w_out_of_range  = 1'b0;
`endif

    assign w_idx       = r_off[IW+1:2];
    assign w_lane      = r_off[1:0];
    assign w_do_access = (r_state == S_ACCESS) && (r_cnt == 4'd0);
    assign w_word      = mem[w_idx];
    assign w_byte      = w_word[8*w_lane +: 8];
    assign w_half      = r_off[1] ? w_word[31:16] : w_word[15:0];

    always_comb begin
        w_load = w_word;
        case (r_size)
            2'b00:   w_load = {{24{r_sign_ext & w_byte[7]}}, w_byte};
            2'b01:   w_load = {{16{r_sign_ext & w_half[15]}}, w_half};
            default: w_load = w_word;
        endcase
    end

    // Store data is replicated across lanes so the byte enables pick the slot.
    always_comb begin
        w_be     = 4'b1111;
        w_wlanes = r_wdata;
        case (r_size)
            2'b00: begin
                w_be     = 4'b0001 << w_lane;
                w_wlanes = {4{r_wdata[7:0]}};
            end
            2'b01: begin
                w_be     = r_off[1] ? 4'b1100 : 4'b0011;
                w_wlanes = {2{r_wdata[15:0]}};
            end
            default: begin
                w_be     = 4'b1111;
                w_wlanes = r_wdata;
            end
        endcase
    end

    // Storage is never reset; reset only blocks a write on the access edge.
    always_ff @(posedge clk) begin
        if (!rst && w_do_access && r_we) begin
            for (int i = 0; i < 4; i++) begin
                if (w_be[i]) begin
                    mem[w_idx][8*i +: 8] <= w_wlanes[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_cnt      <= 4'd0;
            r_rdata    <= 32'd0;
            r_err_pend <= 1'b0;
            r_we       <= 1'b0;
            r_sign_ext <= 1'b0;
            r_size     <= 2'b00;
            r_off      <= '0;
            r_wdata    <= 32'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (req) begin
                        r_we       <= we;
                        r_size     <= size;
                        r_sign_ext <= sign_ext;
                        r_off      <= w_off[IW+1:0];
                        r_wdata    <= wdata;
                        if (w_misaligned || w_out_of_range) begin
                            r_err_pend <= 1'b1;
                            r_state    <= S_RESP;
                        end else begin
                            r_err_pend <= 1'b0;
                            r_cnt      <= c_wait;
                            r_state    <= S_ACCESS;
                        end
                    end
                end
                S_ACCESS: begin
                    if (r_cnt != 4'd0) begin
                        r_cnt <= r_cnt - 4'd1;
                    end else begin
                        if (!r_we) begin
                            r_rdata <= w_load;
                        end
                        r_state <= S_RESP;
                    end
                end
                S_RESP: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign rdata = r_rdata;
    assign ready = (r_state == S_RESP);
    assign err   = (r_state == S_RESP) && r_err_pend;
    assign busy  = (r_state == S_ACCESS) || (r_state == S_RESP);

endmodule
`default_nettype wire

// File: tb/tb_dmem_ls_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_dmem_ls_ctrl
// Purpose  : Scoreboard bench for dmem_ls_ctrl against a byte-array model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dmem_ls_ctrl;

    localparam int          DEPTH = 2048;
    localparam int          WAIT  = 3;
    localparam logic [31:0] BASE  = 32'h1001_0000;
    localparam int unsigned SPAN  = DEPTH * 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        req;
    logic        we;
    logic [1:0]  size;
    logic        sign_ext;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        ready;
    logic        err;
    logic        busy;

    dmem_ls_ctrl #(
        .DEPTH       (DEPTH),
        .BASE_ADDR   (BASE),
        .WAIT_CYCLES (WAIT)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .we       (we),
        .size     (size),
        .sign_ext (sign_ext),
        .addr     (addr),
        .wdata    (wdata),
        .rdata    (rdata),
        .ready    (ready),
        .err      (err),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        err;
        logic [31:0] rdata;
        int unsigned cyc;
    } exp_t;

    exp_t        q[$];
    int unsigned cyc = 0;
    int          n_pass = 0;
    int          n_total = 0;
    logic [7:0]  mem_m [SPAN];
    logic [31:0] rdata_m;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void check(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
        n_total++;
        if (act === exp_v) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp_v);
    endfunction

    // Reference: memory as a flat byte array, accesses as byte loops.
    task automatic model(input logic w, input logic [1:0] sz, input logic sx,
                         input logic [31:0] a, input logic [31:0] d,
                         output logic er, output logic [31:0] rd);
        logic [31:0] off;
        logic [31:0] v;
        int unsigned n;
        int unsigned b;
        off = a - BASE;
        n   = 1 << sz;
        b   = off % SPAN;
        er  = (sz == 2'd3) || ((off % n) != 0);
`ifdef DMEM_RANGE_CHECK_EN
        if (off >= SPAN) er = 1'b1;
`endif
        if (!er) begin
            if (w) begin
                for (int i = 0; i < n; i++) mem_m[b + i] = d[8*i +: 8];
            end else begin
                v = 32'd0;
                for (int i = 0; i < n; i++) v[8*i +: 8] = mem_m[b + i];
                if (sx && n < 4 && v[8*n - 1]) begin
                    for (int i = n; i < 4; i++) v[8*i +: 8] = 8'hFF;
                end
                rdata_m = v;
            end
        end
        rd = rdata_m;
    endtask

    task automatic issue(input logic w, input logic [1:0] sz, input logic sx,
                         input logic [31:0] a, input logic [31:0] d);
        exp_t        e;
        logic        er;
        logic [31:0] rd;
        logic        got;
        @(negedge clk);
        model(w, sz, sx, a, d, er, rd);
        e.err   = er;
        e.rdata = rd;
        e.cyc   = cyc + (er ? 1 : WAIT + 2);
        q.push_back(e);
        req = 1'b1; we = w; size = sz; sign_ext = sx; addr = a; wdata = d;
        got = 1'b0;
        for (int k = 0; k < 64 && !got; k++) begin
            @(negedge clk);
            if (ready) got = 1'b1;
        end
        req = 1'b0;
        if (!got) begin
            check("ready_timeout", 32'd0, 32'd1);
            if (q.size() > 0) void'(q.pop_front());
        end
    endtask

    // Abandoned store: reset lands edges_after clock edges past the accept.
    task automatic reset_mid_store(input int edges_after);
        @(negedge clk);
        req = 1'b1; we = 1'b1; size = 2'b10; sign_ext = 1'b0;
        addr = BASE + 32'h40; wdata = 32'h0000_0001;
        repeat (edges_after) @(negedge clk);
        rst = 1'b1; req = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        rdata_m = 32'd0;
        check("rst_mid_ready", {31'd0, ready}, 32'd0);
        check("rst_mid_busy",  {31'd0, busy},  32'd0);
        check("rst_mid_err",   {31'd0, err},   32'd0);
        check("rst_mid_rdata", rdata, 32'd0);
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (!rst) begin
            if (ready) begin
                if (q.size() == 0) begin
                    check("unexpected_ready", 32'd1, 32'd0);
                end else begin
                    e = q.pop_front();
                    check("resp_err",   {31'd0, err},  {31'd0, e.err});
                    check("resp_rdata", rdata, e.rdata);
                    check("resp_cycle", cyc, e.cyc);
                    check("resp_busy",  {31'd0, busy}, 32'd1);
                end
            end else begin
                check("err_idle", {31'd0, err}, 32'd0);
            end
        end
    end

    initial begin
        logic [1:0]  sz;
        logic [31:0] a;
        int          r;
        for (int i = 0; i < SPAN; i++) mem_m[i] = 8'h00;
        rdata_m = 32'd0;
        rst = 1'b1; req = 1'b0; we = 1'b0; size = 2'b00; sign_ext = 1'b0;
        addr = 32'd0; wdata = 32'd0;
        repeat (3) @(negedge clk);
        check("reset_rdata", rdata, 32'd0);
        check("reset_ready", {31'd0, ready}, 32'd0);
        check("reset_err",   {31'd0, err},   32'd0);
        check("reset_busy",  {31'd0, busy},  32'd0);
        rst = 1'b0;

        issue(1'b1, 2'b10, 1'b0, BASE + 32'h10, 32'hDEAD_BEEF);
        issue(1'b0, 2'b10, 1'b0, BASE + 32'h10, 32'h0);
        issue(1'b1, 2'b00, 1'b0, BASE + 32'h33, 32'h0000_0080);
        issue(1'b0, 2'b10, 1'b0, BASE + 32'h30, 32'h0);
        issue(1'b0, 2'b00, 1'b1, BASE + 32'h33, 32'h0);
        issue(1'b0, 2'b00, 1'b0, BASE + 32'h33, 32'h0);
        issue(1'b1, 2'b10, 1'b0, BASE + 32'h20, 32'hAAAA_BBBB);
        issue(1'b1, 2'b01, 1'b0, BASE + 32'h22, 32'h1234_8001);
        issue(1'b0, 2'b01, 1'b1, BASE + 32'h22, 32'h0);
        issue(1'b0, 2'b01, 1'b0, BASE + 32'h22, 32'h0);
        issue(1'b0, 2'b10, 1'b0, BASE + 32'h20, 32'h0);
        issue(1'b0, 2'b10, 1'b0, BASE + 32'h02, 32'h0);
        issue(1'b1, 2'b01, 1'b0, BASE + 32'h01, 32'hFFFF_FFFF);
        issue(1'b1, 2'b11, 1'b0, BASE + 32'h00, 32'hFFFF_FFFF);
        issue(1'b0, 2'b10, 1'b0, BASE + 32'h00, 32'h0);
        issue(1'b1, 2'b10, 1'b0, BASE + 32'h40, 32'h5555_5555);
        reset_mid_store(2);
        issue(1'b0, 2'b10, 1'b0, BASE + 32'h40, 32'h0);
        reset_mid_store(WAIT + 1);
        issue(1'b0, 2'b10, 1'b0, BASE + 32'h40, 32'h0);
        issue(1'b1, 2'b10, 1'b0, BASE + 32'h2000, 32'hCAFE_F00D);
        issue(1'b0, 2'b10, 1'b0, BASE + 32'h0, 32'h0);

        for (int t = 0; t < 200; t++) begin
            r  = int'($urandom_range(0, 9));
            sz = (r < 3) ? 2'd0 : (r < 6) ? 2'd1 : (r < 9) ? 2'd2 : 2'd3;
            r  = int'($urandom_range(0, 19));
            if (r == 0)      a = BASE + 32'h2000 + $urandom_range(0, 255);
            else if (r == 1) a = $urandom;
            else             a = BASE + $urandom_range(0, 255);
            if (sz != 2'd3 && $urandom_range(0, 3) != 0) a = a & ~((32'd1 << sz) - 32'd1);
            issue(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a, $urandom);
        end

        repeat (4) @(negedge clk);
        check("queue_drained", q.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/dmem_ls_ctrl.md
Name: dmem_ls_ctrl

Overview:
Parametrised data memory for the CPU's load/store path. It replaces the fixed 2048x32 word-only, combinational-read memory with a byte-addressed memory. It supports byte, halfword and word accesses with sign or zero extension on loads and alignment checking. Every access uses a req/ready handshake with a programmable number of wait states. It sits between the CPU MEM stage (or the multi-cycle controller) and storage.

Parameters:
DEPTH, 2048, number of 32-bit words; must be a power of 2; IW = clog2(DEPTH).
BASE_ADDR, 32'h1001_0000, byte address that maps to word 0.
WAIT_CYCLES, 0, extra cycles inserted before the storage access; 0..15.

Ports:
clk  in  1  clock; all state changes on posedge.
rst  in  1  synchronous, active-high reset.
req  in  1  access request; sampled only in IDLE.
we  in  1  1 = store, 0 = load; sampled with req.
size  in  2  00 = byte, 01 = half, 10 = word, 11 = reserved.
sign_ext  in  1  loads only: 1 = sign-extend, 0 = zero-extend.
addr  in  32  byte address.
wdata  in  32  store data, right-aligned (byte in [7:0], half in [15:0]).
rdata  out  32  load result, registered.
ready  out  1  one-cycle completion pulse.
err  out  1  valid with ready: access rejected.
busy  out  1  high while a request is held (ACCESS or RESP state).

Behaviour:
- The clock and reset are as stated: one clock, clk; reset is synchronous and active-high, rst.
- Reset (rst=1 at posedge, highest priority):
  - state=IDLE; rdata=0, ready=0, err=0, busy=0; wait counter=0.
  - Memory contents are NOT cleared by rst. All words are 0 at time zero.
- Offset and index:
  - off = addr - BASE_ADDR (32-bit, wrapping).
  - word index = off[IW+1:2]; lane = off[1:0].
- Misaligned when: size=01 and off[0]=1; or size=10 and off[1:0]!=0; or size=11.
- Storage is little-endian: lane 0 = bits [7:0], lane 3 = bits [31:24].
- State machine:
  - IDLE: busy=0. On req=1, latch we/size/sign_ext/off/wdata.
    - If misaligned (or out of range, see Optional Feature), go to RESP with err pending.
    - Otherwise load cnt=WAIT_CYCLES and go to ACCESS.
  - ACCESS: busy=1.
    - If cnt!=0, decrement cnt.
    - If cnt==0, perform the access on this edge and go to RESP.
      - Store: write only the enabled lanes. Byte writes lane off[1:0]. Half writes lanes {2*off[1], 2*off[1]+1}. Word writes all four lanes. Other lanes are unchanged.
      - Load: select the lane(s), extend per sign_ext, and register into rdata.
  - RESP: ready=1 for exactly one cycle; err=1 if the request was rejected; then go to IDLE.
- Latency from the accepting edge to ready high:
  - Good access: WAIT_CYCLES+2 cycles.
  - Rejected access: 1 cycle.
- Rejected accesses never modify memory or rdata.
- rdata holds its value until the next successful load. Stores leave rdata unchanged.
- req while busy=1 is ignored and not queued. The requester must hold req until it sees ready, and drop it for at least the RESP cycle. req high in the same cycle ready is high is not accepted; it is resampled in IDLE.
- rst asserted in ACCESS before the access edge: the pending store is abandoned with no write. rst on the access edge itself also suppresses the write (reset has priority).
- Without the optional feature, addresses wrap modulo DEPTH*4 bytes.

Optional Feature:
Macro DMEM_RANGE_CHECK_EN.
- Defined: an access with off >= DEPTH*4 (unsigned) is rejected exactly like a misaligned one. It goes to RESP with ready=1 and err=1 after 1 cycle, with no write and rdata unchanged.
- Undefined: no range check. Out-of-range offsets alias to word index off[IW+1:2].

Test Plan:
1. Reset then word round trip: WAIT_CYCLES=0. Store word addr=BASE+0x10, wdata=32'hDEADBEEF. Load word at the same address -> ready 2 cycles after each accept, err=0, rdata=32'hDEADBEEF.
2. Byte lanes and extension:
   - Store byte addr=BASE+0x13, wdata=32'h0000_0080 over word 32'h0000_0000 -> word becomes 32'h8000_0000.
   - lb (sign_ext=1) at BASE+0x13 -> rdata=32'hFFFF_FF80.
   - lbu -> rdata=32'h0000_0080.
3. Halfword: store half addr=BASE+0x22, wdata=32'h1234_8001 into word 32'hAAAA_BBBB -> word becomes 32'h8001_BBBB. lh at BASE+0x22 -> 32'hFFFF_8001. lhu -> 32'h0000_8001.
4. Misalign: word load at BASE+0x02, half store at BASE+0x01, and size=11 -> ready and err high 1 cycle after accept. Memory and rdata unchanged. busy=1 for exactly that RESP cycle.
5. Wait states and reset mid-access: WAIT_CYCLES=3. Store word 32'h5555_5555 to BASE+0x40 -> ready 5 cycles after accept. Repeat with wdata=32'h1 and assert rst 2 cycles after accept -> outputs return to 0, state IDLE, and a subsequent load of BASE+0x40 returns 32'h5555_5555.
6. Range: DEPTH=2048, access BASE+0x2000.
   - With DMEM_RANGE_CHECK_EN defined -> err=1, no write.
   - Without it -> the access aliases to word 0 (a store lands at BASE+0x0).
